// File: rtl/mdu_pkg.sv
// Shared definitions for the execute stage: ALU/MDU op codes, op type, MDU state
// enum and width constants. Imported by the controller and by the MDU itself.
package mdu_pkg;

    localparam int XLEN      = 32;
    localparam int DIV_ITERS = 32;

    typedef logic [4:0] alu_op_t;

    localparam alu_op_t OP_ADD    = 5'b00000;
    localparam alu_op_t OP_SUB    = 5'b00001;
    localparam alu_op_t OP_SLL    = 5'b00010;
    localparam alu_op_t OP_SLT    = 5'b00011;
    localparam alu_op_t OP_SLTU   = 5'b00100;
    localparam alu_op_t OP_XOR    = 5'b00101;
    localparam alu_op_t OP_SRL    = 5'b00110;
    localparam alu_op_t OP_SRA    = 5'b00111;
    localparam alu_op_t OP_OR     = 5'b01000;
    localparam alu_op_t OP_AND    = 5'b01001;
    localparam alu_op_t OP_LUI    = 5'b01010;
    localparam alu_op_t OP_MUL    = 5'b01011;
    localparam alu_op_t OP_MULH   = 5'b01100;
    localparam alu_op_t OP_MULHSU = 5'b01101;
    localparam alu_op_t OP_MULHU  = 5'b01110;
    localparam alu_op_t OP_DIV    = 5'b01111;
    localparam alu_op_t OP_DIVU   = 5'b10000;
    localparam alu_op_t OP_REM    = 5'b10001;
    localparam alu_op_t OP_REMU   = 5'b10010;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ONE,
        S_DIV,
        S_FIN
    } mdu_state_t;

endpackage

// File: rtl/mdu_div_core.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit per cycle.
// quo/rem are the values after the current iteration, so they are final while last is high.
module mdu_div_core
    import mdu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            flush,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            last,
    output logic [XLEN-1:0] quo,
    output logic [XLEN-1:0] rem
);

    localparam logic [4:0] LAST_CNT = 5'(DIV_ITERS - 1);

    logic            active;
    logic [4:0]      cnt;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;

    // Quotient register doubles as the dividend shifter: its MSB feeds the remainder.
    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        diff    = shifted - {1'b0, dvs_q};
        quo     = {quo_q[XLEN-2:0], ~diff[XLEN]};
        rem     = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
        last    = active && (cnt == LAST_CNT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active <= 1'b0;
            cnt    <= '0;
        end else if (flush) begin
            active <= 1'b0;
            cnt    <= '0;
        end else if (load) begin
            active <= 1'b1;
            cnt    <= '0;
        end else if (active) begin
            cnt <= cnt + 5'd1;
            if (last)
                active <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
        end else if (active) begin
            rem_q <= rem;
            quo_q <= quo;
        end
    end

endmodule

// File: rtl/mdu.sv
// RV32M multiply/divide unit: two-cycle multiplies and divide special cases,
// 32-iteration restoring divides, with flush and back-to-back issue from FIN.
module mdu
    import mdu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [4:0]      alu_op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    mdu_state_t state;
    alu_op_t    op;
    logic       is_mul, is_div, sgn_div, want_rem, div_zero, div_ovf, special;
    logic       can_accept, accept, core_load, core_last;
    logic [XLEN-1:0] special_res, a_mag, b_mag, quo_raw, rem_raw;

    alu_op_t         op_q;
    logic [XLEN-1:0] a_q, b_q, spec_q;
    logic            neg_quo_q, neg_rem_q, rem_sel_q;

    logic                   a_sx, b_sx;
    logic signed [63:0]     a_ext, b_ext, prod;
    logic [XLEN-1:0]        mul_res, one_res, div_res;

    // Decode and special-case detection on the live operands at acceptance.
    always_comb begin
        op          = alu_op_i;
        is_mul      = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
        is_div      = (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
        sgn_div     = (op == OP_DIV) || (op == OP_REM);
        want_rem    = (op == OP_REM) || (op == OP_REMU);
        div_zero    = (rs2_i == '0);
        div_ovf     = sgn_div && (rs1_i == 32'h8000_0000) && (rs2_i == 32'hFFFF_FFFF);
        special     = is_div && (div_zero || div_ovf);
        special_res = div_zero ? (want_rem ? rs1_i : 32'hFFFF_FFFF)
                               : (want_rem ? 32'h0 : 32'h8000_0000);
        a_mag       = cond_neg(rs1_i, sgn_div && rs1_i[XLEN-1]);
        b_mag       = cond_neg(rs2_i, sgn_div && rs2_i[XLEN-1]);
        can_accept  = (state == S_IDLE) || (state == S_FIN);
        accept      = start_i && (is_mul || is_div) && can_accept && !flush_i;
        core_load   = accept && is_div && !special;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_q      <= op;
            a_q       <= rs1_i;
            b_q       <= rs2_i;
            spec_q    <= special_res;
            neg_quo_q <= sgn_div && (rs1_i[XLEN-1] ^ rs2_i[XLEN-1]);
            neg_rem_q <= sgn_div && rs1_i[XLEN-1];
            rem_sel_q <= want_rem;
        end
    end

    // 33-bit operands (sign- or zero-extended) multiplied at 64-bit result width.
    always_comb begin
        a_sx    = ((op_q == OP_MULH) || (op_q == OP_MULHSU)) && a_q[XLEN-1];
        b_sx    = (op_q == OP_MULH) && b_q[XLEN-1];
        a_ext   = {{32{a_sx}}, a_q};
        b_ext   = {{32{b_sx}}, b_q};
        prod    = a_ext * b_ext;
        mul_res = (op_q == OP_MUL) ? prod[31:0] : prod[63:32];
        one_res = ((op_q == OP_DIV) || (op_q == OP_DIVU) || (op_q == OP_REM) || (op_q == OP_REMU))
                  ? spec_q : mul_res;
        div_res = rem_sel_q ? cond_neg(rem_raw, neg_rem_q) : cond_neg(quo_raw, neg_quo_q);
    end

    mdu_div_core u_div_core (
        .clk      (clk),
        .rst      (rst),
        .load     (core_load),
        .flush    (flush_i),
        .dividend (a_mag),
        .divisor  (b_mag),
        .last     (core_last),
        .quo      (quo_raw),
        .rem      (rem_raw)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            result_o <= '0;
        end else begin
            busy_o <= 1'b0;
            done_o <= 1'b0;
            if (flush_i) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE, S_FIN: begin
                        if (accept) begin
                            state  <= (is_div && !special) ? S_DIV : S_ONE;
                            busy_o <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    S_ONE: begin
                        state    <= S_FIN;
                        done_o   <= 1'b1;
                        result_o <= one_res;
                    end
                    S_DIV: begin
                        if (core_last) begin
                            state    <= S_FIN;
                            done_o   <= 1'b1;
                            result_o <= div_res;
                        end else begin
                            busy_o <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: latency, busy window, results, special cases, flush,
// back-to-back issue from FIN, mid-divide reset and ignored op codes.
module tb_mdu;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start_i, flush_i;
    logic [4:0]  alu_op_i;
    logic [31:0] rs1_i, rs2_i;
    logic        busy_o, done_o;
    logic [31:0] result_o;

    int total = 0;
    int bad   = 0;

    mdu dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .alu_op_i (alu_op_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .flush_i  (flush_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a start for one edge, then scramble operands to prove they were captured.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        start_i  = 1'b1;
        alu_op_i = op;
        rs1_i    = a;
        rs2_i    = b;
        tick();
        start_i  = 1'b0;
        rs1_i    = ~a ^ 32'h5A5A_1234;
        rs2_i    = b + 32'd3;
        alu_op_i = OP_ADD;
    endtask

    // Called in cycle k+1; returns in the done cycle.
    task automatic wait_done(input string tag, input int exp_lat, input logic [31:0] exp_res);
        int cycles = 1;
        int busy_cnt = 0;
        while (done_o !== 1'b1 && cycles < 60) begin
            if (busy_o === 1'b1) busy_cnt++;
            tick();
            cycles++;
        end
        chk({tag, " done"}, 32'(done_o), 32'd1);
        chk({tag, " latency"}, 32'(cycles), 32'(exp_lat));
        chk({tag, " busy cycles"}, 32'(busy_cnt), 32'(exp_lat - 1));
        chk({tag, " busy in FIN"}, 32'(busy_o), 32'd0);
        chk({tag, " result"}, result_o, exp_res);
    endtask

    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
        issue(op, a, b);
        wait_done(tag, exp_lat, exp_res);
        tick();
        chk({tag, " done single pulse"}, 32'(done_o), 32'd0);
        chk({tag, " result hold"}, result_o, exp_res);
    endtask

    initial begin
        int seen_done;
        rst = 1'b1; start_i = 1'b0; flush_i = 1'b0;
        alu_op_i = OP_ADD; rs1_i = '0; rs2_i = '0;
        tick(); tick();
        rst = 1'b0;
        chk("reset busy", 32'(busy_o), 32'd0);
        chk("reset done", 32'(done_o), 32'd0);
        chk("reset result", result_o, 32'd0);

        run_op("MUL",    OP_MUL,    32'd7,          32'hFFFF_FFFD, 2, 32'hFFFF_FFEB);
        run_op("MULH",   OP_MULH,   32'h8000_0000,  32'h8000_0000, 2, 32'h4000_0000);
        run_op("MULHU",  OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 2, 32'hFFFF_FFFE);
        run_op("MULHSU", OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 2, 32'hFFFF_FFFF);
        run_op("DIV",    OP_DIV,    32'hFFFF_FFF9,  32'd2,         33, 32'hFFFF_FFFD);
        run_op("REM",    OP_REM,    32'hFFFF_FFF9,  32'd2,         33, 32'hFFFF_FFFF);
        run_op("DIV neg divisor", OP_DIV, 32'd20,   32'hFFFF_FFFD, 33, 32'hFFFF_FFFA);
        run_op("REM neg divisor", OP_REM, 32'd20,   32'hFFFF_FFFD, 33, 32'd2);
        run_op("REMU",   OP_REMU,   32'd100,        32'd7,         33, 32'd2);
        run_op("DIVU by zero", OP_DIVU, 32'd5,      32'd0,         2, 32'hFFFF_FFFF);
        run_op("REMU by zero", OP_REMU, 32'd5,      32'd0,         2, 32'd5);
        run_op("DIV ovf", OP_DIV,   32'h8000_0000,  32'hFFFF_FFFF, 2, 32'h8000_0000);
        run_op("REM ovf", OP_REM,   32'h8000_0000,  32'hFFFF_FFFF, 2, 32'd0);
        run_op("DIVU",   OP_DIVU,   32'd100,        32'd7,         33, 32'd14);

        // Flush in cycle k+10 of a divide; result must keep 14.
        issue(OP_DIV, 32'd1000, 32'd3);
        seen_done = 0;
        for (int i = 0; i < 9; i++) begin
            if (done_o === 1'b1) seen_done++;
            tick();
        end
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("flush busy", 32'(busy_o), 32'd0);
        chk("flush no done", 32'(seen_done + int'(done_o)), 32'd0);
        chk("flush result held", result_o, 32'd14);
        run_op("after flush", OP_DIVU, 32'd1000, 32'd10, 33, 32'd100);

        // Back-to-back: new start in the FIN cycle of a multiply.
        issue(OP_MUL, 32'd3, 32'd5);
        wait_done("b2b first", 2, 32'd15);
        issue(OP_DIVU, 32'd1000, 32'd8);
        chk("b2b busy after FIN issue", 32'(busy_o), 32'd1);
        chk("b2b done dropped", 32'(done_o), 32'd0);
        wait_done("b2b second", 33, 32'd125);
        tick();
        chk("b2b single pulse", 32'(done_o), 32'd0);

        // Reset in the middle of a divide.
        issue(OP_DIVU, 32'd77, 32'd5);
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid rst busy", 32'(busy_o), 32'd0);
        chk("mid rst done", 32'(done_o), 32'd0);
        chk("mid rst result", result_o, 32'd0);
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (done_o === 1'b1 || busy_o === 1'b1) seen_done++;
            tick();
        end
        chk("mid rst no completion", 32'(seen_done), 32'd0);

        // Non-MDU op code is ignored.
        issue(OP_ADD, 32'd9, 32'd9);
        chk("ADD ignored busy", 32'(busy_o), 32'd0);
        tick();
        chk("ADD ignored done", 32'(done_o), 32'd0);
        chk("ADD ignored result", result_o, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
